requant_lanes: RTL and testbench



---
 rtl/requant_lanes.sv | 208 ++++++++++++++++++++
 tb/tb_requant_lanes.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_lanes.sv
// ============================================================================
// Module   : requant_lanes
// Brief    : Multi-lane per-channel requantizer: int32 accumulators -> OUT_W
//            activations via multiply, rounding shift, zero point and clamp.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module requant_lanes #(
    parameter int LANES  = 4,
    parameter int IN_W   = 32,
    parameter int OUT_W  = 8,
    parameter int NUM_CH = 16,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_addr,
    input  logic [31:0]             cfg_mult,
    input  logic [5:0]              cfg_shift,
    input  logic [OUT_W-1:0]        cfg_zp,
    input  logic                    out_unsigned,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*IN_W-1:0]   s_data,
    input  logic [CH_W-1:0]         s_ch,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*OUT_W-1:0]  m_data,
    output logic [LANES-1:0]        m_sat,
    output logic [31:0]             sat_cnt,
    input  logic                    sat_clr
);

    localparam int PROD_W = IN_W + 32;
    localparam int RND_W  = PROD_W + 1;
    localparam int Y_W    = PROD_W + 2;

    localparam logic signed [Y_W-1:0] C_S_MAX = (Y_W'(1) << (OUT_W - 1)) - Y_W'(1);
    localparam logic signed [Y_W-1:0] C_S_MIN = -C_S_MAX - Y_W'(1);
    localparam logic signed [Y_W-1:0] C_U_MAX = (Y_W'(1) << OUT_W) - Y_W'(1);

    // Per-channel scale table
    logic signed [31:0]      r_tab_mult  [NUM_CH];
    logic [5:0]              r_tab_shift [NUM_CH];
    logic signed [OUT_W-1:0] r_tab_zp    [NUM_CH];

    // Stage registers
    logic                    r_v1, r_v2, r_v3, r_v4;
    logic [LANES*IN_W-1:0]   r_data1;
    logic signed [31:0]      r_mult1;
    logic [5:0]              r_shift1, r_shift2;
    logic signed [OUT_W-1:0] r_zp1, r_zp2, r_zp3;
    logic                    r_uns1, r_uns2, r_uns3;
    logic signed [PROD_W-1:0] r_prod2 [LANES];
    logic signed [RND_W-1:0]  r_rnd3  [LANES];
    logic [LANES*OUT_W-1:0]  r_mdata;
    logic [LANES-1:0]        r_msat;
    logic [31:0]             r_sat_cnt;

    logic                     w_adv;
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [RND_W-1:0]  w_rnd  [LANES];
    logic [LANES*OUT_W-1:0]   w_q;
    logic [LANES-1:0]         w_sat;
    logic [32:0]              w_pop;
    logic [32:0]              w_cnt_sum;

    // Single global advance: whole pipe moves or whole pipe holds.
    assign w_adv   = ~r_v4 | m_ready;
    assign s_ready = w_adv;
    assign m_valid = r_v4;
    assign m_data  = r_mdata;
    assign m_sat   = r_msat;
    assign sat_cnt = r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_tab_mult[c]  <= '0;
                r_tab_shift[c] <= '0;
                r_tab_zp[c]    <= '0;
            end
        end else if (cfg_we) begin
            r_tab_mult[cfg_addr]  <= cfg_mult;
            r_tab_shift[cfg_addr] <= cfg_shift;
            r_tab_zp[cfg_addr]    <= cfg_zp;
        end
    end

    // Control and per-beat sideband through the stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_v4     <= 1'b0;
            r_data1  <= '0;
            r_mult1  <= '0;
            r_shift1 <= '0;
            r_shift2 <= '0;
            r_zp1    <= '0;
            r_zp2    <= '0;
            r_zp3    <= '0;
            r_uns1   <= 1'b0;
            r_uns2   <= 1'b0;
            r_uns3   <= 1'b0;
        end else if (w_adv) begin
            r_v1     <= s_valid;
            r_v2     <= r_v1;
            r_v3     <= r_v2;
            r_v4     <= r_v3;
            r_data1  <= s_data;
            r_mult1  <= r_tab_mult[s_ch];
            r_shift1 <= r_tab_shift[s_ch];
            r_zp1    <= r_tab_zp[s_ch];
            r_uns1   <= out_unsigned;
            r_shift2 <= r_shift1;
            r_zp2    <= r_zp1;
            r_uns2   <= r_uns1;
            r_zp3    <= r_zp2;
            r_uns3   <= r_uns2;
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [IN_W-1:0]  w_acc;
            logic signed [RND_W-1:0] w_ext;
            logic signed [RND_W-1:0] w_bias;
            logic signed [RND_W-1:0] w_sum;
            logic signed [Y_W-1:0]   w_y;
            logic signed [Y_W-1:0]   w_hi;
            logic signed [Y_W-1:0]   w_lo;
            logic [OUT_W-1:0]        w_lq;
            logic                    w_ls;

            assign w_acc     = r_data1[i*IN_W +: IN_W];
            assign w_prod[i] = PROD_W'(w_acc) * PROD_W'(r_mult1);

            // One extra bit keeps the half-LSB bias from wrapping.
            assign w_ext    = RND_W'(r_prod2[i]);
            assign w_bias   = (r_shift2 == 6'd0) ? '0 : (RND_W'(1) << (r_shift2 - 6'd1));
            assign w_sum    = w_ext + w_bias;
            assign w_rnd[i] = w_sum >>> r_shift2;

            assign w_y  = Y_W'(r_rnd3[i]) + Y_W'(r_zp3);
            assign w_hi = r_uns3 ? C_U_MAX : C_S_MAX;
            assign w_lo = r_uns3 ? '0 : C_S_MIN;

            always_comb begin
                w_lq = w_y[OUT_W-1:0];
                w_ls = 1'b0;
                if (w_y > w_hi) begin
                    w_lq = w_hi[OUT_W-1:0];
                    w_ls = 1'b1;
                end else if (w_y < w_lo) begin
                    w_lq = w_lo[OUT_W-1:0];
                    w_ls = 1'b1;
                end
            end

            assign w_q[i*OUT_W +: OUT_W] = w_lq;
            assign w_sat[i]              = w_ls;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                r_prod2[l] <= '0;
                r_rnd3[l]  <= '0;
            end
            r_mdata <= '0;
            r_msat  <= '0;
        end else if (w_adv) begin
            for (int l = 0; l < LANES; l++) begin
                r_prod2[l] <= w_prod[l];
                r_rnd3[l]  <= w_rnd[l];
            end
            r_mdata <= w_q;
            r_msat  <= w_sat;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pop = w_pop + 33'(r_msat[l]);
        end
    end

    assign w_cnt_sum = {1'b0, r_sat_cnt} + w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_v4 && m_ready) begin
            r_sat_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_requant_lanes.sv
// ============================================================================
// Module   : tb_requant_lanes
// Brief    : Self-checking bench for requant_lanes with a 128-bit arithmetic
//            reference model and an in-order expected-beat queue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_requant_lanes;

    localparam int LANES  = 4;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 8;
    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [CH_W-1:0]        cfg_addr = '0;
    logic [31:0]            cfg_mult = '0;
    logic [5:0]             cfg_shift = '0;
    logic [OUT_W-1:0]       cfg_zp = '0;
    logic                   out_unsigned = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [LANES*IN_W-1:0]  s_data = '0;
    logic [CH_W-1:0]        s_ch = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b1;
    logic [LANES*OUT_W-1:0] m_data;
    logic [LANES-1:0]       m_sat;
    logic [31:0]            sat_cnt;
    logic                   sat_clr = 1'b0;

    int checks = 0;
    int errs   = 0;
    bit bp_en  = 1'b0;

    requant_lanes #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .out_unsigned(out_unsigned), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_sat(m_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic signed [31:0] t_mult  [NUM_CH];
    logic [5:0]         t_shift [NUM_CH];
    logic signed [7:0]  t_zp    [NUM_CH];
    logic [35:0]        exp_q [$];
    logic [31:0]        mcnt = '0;
    bit                 prev_stall = 1'b0;
    logic [35:0]        prev_out;

    function automatic void ref_lane(input logic signed [31:0] a, input logic signed [31:0] m,
                                     input logic [5:0] sh, input logic signed [7:0] zp,
                                     input logic uns, output logic [7:0] q, output logic s);
        logic signed [127:0] p, lo, hi;
        p = a;
        p = p * m;
        if (sh != 0) p = (p + (128'sd1 <<< (sh - 1))) >>> sh;
        p = p + zp;
        if (uns) begin lo = 0;    hi = 255; end
        else     begin lo = -128; hi = 127; end
        q = p[7:0];
        s = 1'b0;
        if (p > hi)      begin q = hi[7:0]; s = 1'b1; end
        else if (p < lo) begin q = lo[7:0]; s = 1'b1; end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mcnt = '0;
            prev_stall = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                t_mult[c] = '0; t_shift[c] = '0; t_zp[c] = '0;
            end
        end else begin
            logic [35:0] e;
            logic [31:0] ed;
            logic [3:0]  es;
            logic [7:0]  q;
            logic        s;
            bit          hs;
            longint      t;
            checks++;
            assert (sat_cnt === mcnt) else begin
                errs++; $error("FAIL sat_cnt obs=%0d exp=%0d", sat_cnt, mcnt);
            end
            if (prev_stall) begin
                checks++;
                assert ({m_sat, m_data} === prev_out) else begin
                    errs++; $error("FAIL stall_hold obs=%h exp=%h", {m_sat, m_data}, prev_out);
                end
            end
            hs = m_valid && m_ready;
            e = '0;
            if (hs) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errs++; $error("FAIL unexpected_beat obs=%h exp=none", {m_sat, m_data});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert ({m_sat, m_data} === e) else begin
                        errs++; $error("FAIL beat obs=%h exp=%h", {m_sat, m_data}, e);
                    end
                end
            end
            if (sat_clr) mcnt = '0;
            else if (hs) begin
                t = longint'(mcnt) + $countones(e[35:32]);
                mcnt = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
            end
            if (s_valid && s_ready) begin
                for (int l = 0; l < LANES; l++) begin
                    ref_lane(s_data[l*IN_W +: IN_W], t_mult[s_ch], t_shift[s_ch], t_zp[s_ch],
                             out_unsigned, q, s);
                    ed[l*8 +: 8] = q;
                    es[l] = s;
                end
                exp_q.push_back({es, ed});
            end
            if (cfg_we) begin
                t_mult[cfg_addr] = cfg_mult; t_shift[cfg_addr] = cfg_shift; t_zp[cfg_addr] = cfg_zp;
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_sat, m_data};
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic write_tab(input int ch, input logic [31:0] m, input int sh, input logic [7:0] zp);
        cfg_we = 1'b1; cfg_addr = CH_W'(ch); cfg_mult = m; cfg_shift = 6'(sh); cfg_zp = zp;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input int ch);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_ch = CH_W'(ch);
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) begin
                errs++; $error("FAIL accept_timeout obs=%0d exp=<=200", t);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            step(); t++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errs++; $error("FAIL drain obs=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        logic [31:0] rm;
        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; assert (s_ready === 1'b1) else begin errs++; $error("FAIL rst_s_ready obs=%b exp=1", s_ready); end
        checks++; assert (m_valid === 1'b0) else begin errs++; $error("FAIL rst_m_valid obs=%b exp=0", m_valid); end
        checks++; assert (m_data === 32'h0) else begin errs++; $error("FAIL rst_m_data obs=%h exp=0", m_data); end
        checks++; assert (m_sat === 4'h0) else begin errs++; $error("FAIL rst_m_sat obs=%h exp=0", m_sat); end
        step();

        // Identity with latency check
        write_tab(0, 32'd1, 0, 8'd0);
        send(pack4(5, -3, 127, -128), 0);
        step(); step();
        checks++; assert (m_valid === 1'b0) else begin errs++; $error("FAIL early_valid obs=%b exp=0", m_valid); end
        step();
        checks++; assert (m_valid === 1'b1) else begin errs++; $error("FAIL lat_valid obs=%b exp=1", m_valid); end
        checks++; assert (m_data === 32'h807FFD05) else begin errs++; $error("FAIL identity obs=%h exp=807ffd05", m_data); end
        drain();

        // Rounding shift
        write_tab(1, 32'd3, 2, 8'd0);
        send(pack4(5, 6, -5, -6), 1);
        drain();

        // Saturation and counter
        send(pack4(200, -200, 1000, 0), 0);
        drain();
        checks++; assert (sat_cnt === 32'd3) else begin errs++; $error("FAIL sat_cnt3 obs=%0d exp=3", sat_cnt); end
        sat_clr = 1'b1; step(); sat_clr = 1'b0;
        checks++; assert (sat_cnt === 32'd0) else begin errs++; $error("FAIL sat_clr obs=%0d exp=0", sat_cnt); end

        // Unsigned output with negative zero point
        write_tab(3, 32'd1, 0, 8'h80);
        out_unsigned = 1'b1;
        send(pack4(-5, 300, 128, 383), 3);
        out_unsigned = 1'b0;
        drain();

        // Backpressure, alternating channels
        bp_en = 1'b1;
        for (int k = 0; k < 10; k++) send(pack4(k * 37 - 150, -k * 11, k * 90, 3 - k), k % 2);
        drain();

        // Same-cycle table write and accept on ch2
        bp_en = 1'b0;
        write_tab(2, 32'd2, 0, 8'd0);
        step();
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_mult = 32'd5; cfg_shift = 6'd1; cfg_zp = 8'd3;
        s_valid = 1'b1; s_data = pack4(10, -10, 20, 7); s_ch = 4'd2;
        step();
        cfg_we = 1'b0;
        s_data = pack4(10, -10, 20, 7);
        step();
        s_valid = 1'b0;
        drain();

        // Randomized stream against the model
        bp_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rm = 32'($signed($urandom_range(0, 64)) - 32);
                    1:       rm = $urandom;
                    default: rm = 32'd1 << $urandom_range(0, 31);
                endcase
                write_tab($urandom_range(0, NUM_CH - 1), rm, $urandom_range(0, 63), 8'($urandom));
            end
            out_unsigned = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                send(pack4($urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000,
                           $urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000),
                     $urandom_range(0, NUM_CH - 1));
            else
                send({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 5) == 0) step();
        end
        drain();
        out_unsigned = 1'b0;

        // Reset with beats in flight
        bp_en = 1'b0;
        send(pack4(200, -200, 1000, 0), 0);
        drain();
        send(pack4(1, 2, 3, 4), 0);
        send(pack4(500, 500, 500, 500), 0);
        send(pack4(-900, 2, 3, 4), 0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; assert (m_valid === 1'b0) else begin errs++; $error("FAIL post_rst_valid obs=%b exp=0", m_valid); end
            checks++; assert (sat_cnt === 32'd0) else begin errs++; $error("FAIL post_rst_cnt obs=%0d exp=0", sat_cnt); end
        end
        step();
        // Table must be zeroed: any beat now maps to zero.
        send(pack4(1000, -77, 5, 123456), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

`default_nettype wire
